riscv_fetch: RTL and testbench
==============================

Name: riscv_fetch

Overview:
Instruction-fetch stage. Generates the PC, runs the instruction-memory request/acknowledge handshake, and presents {pc, instr, valid} to the IF/ID pipeline register. Obeys the hazard unit's stall and the EX-stage redirect (taken branch/jump). Contains a two-entry buffer (output plus skid) so that a stall never loses or duplicates an acknowledged fetch.

Parameters:
RESET_PC  32'h0000_0000  first fetch address after reset
XLEN      32             address/instruction width

Ports:
clk_i          in   1     clock, `CLOCK_EDGE
rst_i          in   1     asynchronous active-high reset
stall_i        in   1     downstream IF/ID stalled; output must hold
redirect_i     in   1     EX redirect; flushes fetch state
redirect_pc_i  in   XLEN  redirect target
imem_req_o     out  1     memory request
imem_addr_o    out  XLEN  request address; stable while req high
imem_ack_i     in   1     request done; data valid this cycle; may arrive in the same cycle as req
imem_data_i    in   XLEN  instruction word
valid_o        out  1     pc_o/instr_o hold a live instruction
pc_o           out  XLEN  instruction PC
instr_o        out  XLEN  instruction word

Behaviour:
- Async reset:
  - state S_IDLE; imem_req_o=0; imem_addr_o=RESET_PC; pc_q=RESET_PC.
  - valid_o=0, pc_o=0, instr_o=0; skid empty.
  - Reset mid-request abandons the request immediately: req drops without a clock edge.
- Consume rule: the output is consumed at an edge where valid_o=1 and stall_i=0. can_accept = !valid_o || !stall_i.
- States:
  - S_IDLE: req=0. Goes to S_REQ the next cycle unconditionally (the first edge after reset release).
  - S_REQ: req=1, addr=req_addr_q.
    - ack & can_accept: output <= {req_addr_q, imem_data_i}, valid=1; req_addr_q += 4; stay S_REQ. Back-to-back throughput is 1 instruction/cycle.
    - ack & !can_accept: skid <= {req_addr_q, data}; req_addr_q += 4; go S_SKID.
    - no ack: hold addr, stay.
  - S_SKID: req=0. When stall_i=0, skid moves to output; go S_REQ.
  - S_DROP: req=1, addr held at the stale address. On ack, data is discarded, req_addr_q <= pc_q, go S_REQ.
- Redirect (highest priority, beats stall_i in the same cycle):
  - valid_o <= 0 and skid cleared; pc_q and req_addr_q <= target.
  - From S_REQ without ack that cycle: go S_DROP. The outstanding request completes and is discarded; req_addr_q holds the stale address until that ack.
  - From S_REQ with ack, S_SKID or S_IDLE: go S_REQ at the target.
  - From S_DROP: update pc_q, stay S_DROP.
- Latency: zero-wait memory gives the instruction on valid_o one cycle after the ack edge.
- Address arithmetic is modulo 2^XLEN; wrap from 0xFFFF_FFFC to 0 is legal.
- The request address is never changed while req=1 and no ack has been received.

Optional Feature:
RISCV_FETCH_MISALIGN_EN
- Defined:
  - Adds port misalign_o (out, 1, reset 0).
  - A redirect target with [1:0]!=0 issues no request. The output loads {target, 0} with valid=1 and misalign_o=1, and the block parks in S_IDLE until the next redirect.
- Undefined: target[1:0] is forced to 0 and the fetch proceeds normally.

Decomposition:
- define.h (shared constants):
  - state encodings S_IDLE/S_REQ/S_SKID/S_DROP
  - default RESET_PC
  - XLEN
  - the PC increment (4)
- Sub-module riscv_fetch_buf: the two-entry output/skid buffer with clear, load, shift and can_accept logic. The FSM and PC logic stay in the top block.

Test Plan:
1. RESET_PC=0x100; reset held, then released; imem_ack_i tied 1 -> during reset req=0 and addr=0x100. Cycle 1 req=1; valid_o rises the next cycle with pc_o=0x100; then 0x104, 0x108 on consecutive cycles.
2. Streaming with ack=1; stall_i held 3 cycles while pc_o=0x104 -> pc_o stays 0x104, skid holds 0x108, req=0. After release the outputs are 0x108, 0x10C with no gap, loss or duplicate.
3. Request 0x108 outstanding; redirect_i=1 to 0x200; ack arrives 2 cycles later with data 0xDEAD_BEEF -> addr holds 0x108 until that ack; valid_o stays 0 and the data is dropped. Next request is 0x200; valid_o next rises with pc_o=0x200.
4. valid_o=1 with stall_i=1, and redirect_i to 0x300 in the same cycle -> valid_o=0 the next cycle; fetch at 0x300; the stalled instruction is gone.
5. Async reset asserted mid-cycle while req=1 -> imem_req_o and valid_o fall before the next clk_i edge; after release the fetch restarts at RESET_PC.
6. Redirect to 0x202 -> with macro: misalign_o=1, valid_o=1, pc_o=0x202, instr_o=0, no request issued. Without macro: fetch at 0x200.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the riscv_fetch instruction-fetch stage.
package riscv_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF    = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC          = 32'd4;
   localparam logic [XLEN-1:0] ADDR_ALIGN_MASK = 32'h0000_0003;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SKID = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Instruction-memory request/acknowledge bus used by riscv_fetch.
interface riscv_fetch_if;
   import riscv_fetch_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [XLEN-1:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/riscv_fetch_buf.sv
// Two-entry output/skid buffer: output register plus one skid slot so an
// acknowledged fetch that arrives during a stall is parked, never lost.
module riscv_fetch_buf
   import riscv_fetch_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            clr_i,        // flush both entries
   input  logic            load_i,       // write in_* into the output entry
   input  logic            skid_load_i,  // write in_* into the skid entry
   input  logic            shift_i,      // move skid entry into the output
   input  logic [XLEN-1:0] in_pc_i,
   input  logic [XLEN-1:0] in_instr_i,
   output logic            can_accept_o,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o
);

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_instr_q, out_instr_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;

   assign can_accept_o = !out_valid_q || !stall_i;
   assign valid_o      = out_valid_q;
   assign pc_o         = out_pc_q;
   assign instr_o      = out_instr_q;

   // Next-state of both entries; a clear may still carry a load (misaligned redirect).
   always_comb begin
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (clr_i) begin
         skid_valid_d = 1'b0;
         skid_pc_d    = '0;
         skid_instr_d = '0;
         out_valid_d  = load_i;
         if (load_i) begin
            out_pc_d    = in_pc_i;
            out_instr_d = in_instr_i;
         end
      end else if (shift_i) begin
         out_valid_d  = skid_valid_q;
         out_pc_d     = skid_pc_q;
         out_instr_d  = skid_instr_q;
         skid_valid_d = 1'b0;
      end else if (load_i) begin
         out_valid_d = 1'b1;
         out_pc_d    = in_pc_i;
         out_instr_d = in_instr_i;
      end else if (skid_load_i) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = in_pc_i;
         skid_instr_d = in_instr_i;
      end else if (out_valid_q && !stall_i) begin
         out_valid_d = 1'b0;
      end
   end

   // Buffer registers, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: PC generation, imem handshake, redirect handling.
// Optional feature macro: RISCV_FETCH_MISALIGN_EN (misaligned redirect
// targets are reported on misalign_o instead of being fetched).
module riscv_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_pc_i,
   riscv_fetch_if.master     imem,
   output logic              valid_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   instr_o
`ifdef RISCV_FETCH_MISALIGN_EN
   ,
   output logic              misalign_o
`endif
);

   fetch_state_t    state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] pc_q, pc_d;       // latest redirect target
   logic            park_q, park_d;   // parked in S_IDLE after a misaligned target

   logic            ack_live;
   logic            can_accept;
   logic [XLEN-1:0] tgt;
   logic            tgt_mis;
   logic            buf_clr, buf_load, buf_skid_load, buf_shift;
   logic [XLEN-1:0] load_pc, load_instr;

   assign imem.req  = req_q;
   assign imem.addr = req_addr_q;
   assign ack_live  = imem.ack && req_q;

   // Redirect target qualification.
   always_comb begin
`ifdef RISCV_FETCH_MISALIGN_EN
      tgt     = redirect_pc_i;
      tgt_mis = |(redirect_pc_i & ADDR_ALIGN_MASK);
`else
      tgt     = redirect_pc_i & ~ADDR_ALIGN_MASK;
      tgt_mis = 1'b0;
`endif
   end

   // FSM next state, address update and buffer control; redirect has top priority.
   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      pc_d          = pc_q;
      park_d        = park_q;
      buf_clr       = 1'b0;
      buf_load      = 1'b0;
      buf_skid_load = 1'b0;
      buf_shift     = 1'b0;
      load_pc       = req_addr_q;
      load_instr    = imem.data;
      if (redirect_i) begin
         buf_clr = 1'b1;
         pc_d    = tgt;
         park_d  = tgt_mis;
         if (tgt_mis) begin
            buf_load   = 1'b1;
            load_pc    = tgt;
            load_instr = '0;
         end
         if (state_q == S_DROP || (state_q == S_REQ && !ack_live)) begin
            // Outstanding request must finish at its original address.
            state_d = S_DROP;
         end else begin
            req_addr_d = tgt;
            state_d    = tgt_mis ? S_IDLE : S_REQ;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!park_q) state_d = S_REQ;
            end
            S_REQ: begin
               if (ack_live) begin
                  req_addr_d = pc_next(req_addr_q);
                  if (can_accept) begin
                     buf_load = 1'b1;
                  end else begin
                     buf_skid_load = 1'b1;
                     state_d       = S_SKID;
                  end
               end
            end
            S_SKID: begin
               if (!stall_i) begin
                  buf_shift = 1'b1;
                  state_d   = S_REQ;
               end
            end
            S_DROP: begin
               if (ack_live) begin
                  req_addr_d = pc_q;
                  state_d    = park_q ? S_IDLE : S_REQ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      req_d = (state_d == S_REQ) || (state_d == S_DROP);
   end

   // FSM state and registered request outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         req_addr_q <= RESET_PC;
         pc_q       <= RESET_PC;
         park_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         req_addr_q <= req_addr_d;
         pc_q       <= pc_d;
         park_q     <= park_d;
      end
   end

   riscv_fetch_buf u_buf (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .clr_i        (buf_clr),
      .load_i       (buf_load),
      .skid_load_i  (buf_skid_load),
      .shift_i      (buf_shift),
      .in_pc_i      (load_pc),
      .in_instr_i   (load_instr),
      .can_accept_o (can_accept),
      .valid_o      (valid_o),
      .pc_o         (pc_o),
      .instr_o      (instr_o)
   );

`ifdef RISCV_FETCH_MISALIGN_EN
   logic misalign_q, misalign_d;

   assign misalign_o = misalign_q;

   // Flag follows the output entry: set by a misaligned redirect, dropped on consume.
   always_comb begin
      misalign_d = misalign_q;
      if (redirect_i)                misalign_d = tgt_mis;
      else if (valid_o && !stall_i)  misalign_d = 1'b0;
   end

   // Misalign flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed testbench for riscv_fetch (RESET_PC = 0x100).
// Memory model returns ~addr unless an override word is selected.
module tb_riscv_fetch;
   import riscv_fetch_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            stall_i = 1'b0;
   logic            redirect_i = 1'b0;
   logic [XLEN-1:0] redirect_pc_i = '0;
   logic            valid_o;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] instr_o;
`ifdef RISCV_FETCH_MISALIGN_EN
   logic            misalign_o;
`endif

   logic            ack_en = 1'b1;
   logic            ovr_en = 1'b0;
   logic [XLEN-1:0] ovr_data = 32'hDEAD_BEEF;

   int total = 0;
   int bad   = 0;

   riscv_fetch_if imem ();

   riscv_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem          (imem.master),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .instr_o       (instr_o)
`ifdef RISCV_FETCH_MISALIGN_EN
      ,
      .misalign_o    (misalign_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Zero-wait memory: ack in the same cycle as req when enabled.
   always_comb begin
      imem.ack  = ack_en && imem.req;
      imem.data = ovr_en ? ovr_data : ~imem.addr;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // ---- 1: reset state and start-up ----
      #12;
      check_val("rst_req",   {31'd0, imem.req}, 32'd0);
      check_val("rst_addr",  imem.addr, 32'h100);
      check_val("rst_valid", {31'd0, valid_o}, 32'd0);
      check_val("rst_pc",    pc_o, 32'd0);
      check_val("rst_instr", instr_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();
      check_val("t1_req",   {31'd0, imem.req}, 32'd1);
      check_val("t1_addr",  imem.addr, 32'h100);
      check_val("t1_valid", {31'd0, valid_o}, 32'd0);
      tick();
      check_val("t1_v0",    {31'd0, valid_o}, 32'd1);
      check_val("t1_pc0",   pc_o, 32'h100);
      check_val("t1_in0",   instr_o, 32'hFFFF_FEFF);
      tick();
      check_val("t1_pc1",   pc_o, 32'h104);

      // ---- 2: stall for three cycles while pc_o = 0x104 ----
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t2_hold_pc",  pc_o, 32'h104);
         check_val("t2_hold_in",  instr_o, 32'hFFFF_FEFB);
         check_val("t2_hold_req", {31'd0, imem.req}, 32'd0);
         check_val("t2_hold_v",   {31'd0, valid_o}, 32'd1);
      end
      stall_i = 1'b0;
      tick();
      check_val("t2_pc2",   pc_o, 32'h108);
      check_val("t2_in2",   instr_o, 32'hFFFF_FEF7);
      check_val("t2_req",   {31'd0, imem.req}, 32'd1);
      check_val("t2_addr",  imem.addr, 32'h10C);
      tick();
      check_val("t2_pc3",   pc_o, 32'h10C);
      check_val("t2_v3",    {31'd0, valid_o}, 32'd1);

      // ---- 3: redirect with a request outstanding ----
      ack_en = 1'b0;
      tick();
      check_val("t3_v_idle", {31'd0, valid_o}, 32'd0);
      check_val("t3_addr0",  imem.addr, 32'h110);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0;
      check_val("t3_addr1",  imem.addr, 32'h110);
      check_val("t3_req1",   {31'd0, imem.req}, 32'd1);
      check_val("t3_v1",     {31'd0, valid_o}, 32'd0);
      tick();
      check_val("t3_addr2",  imem.addr, 32'h110);
      ack_en = 1'b1;
      ovr_en = 1'b1;
      tick();
      ovr_en = 1'b0;
      check_val("t3_drop_v", {31'd0, valid_o}, 32'd0);
      check_val("t3_addr3",  imem.addr, 32'h200);
      check_val("t3_req3",   {31'd0, imem.req}, 32'd1);
      tick();
      check_val("t3_v4",     {31'd0, valid_o}, 32'd1);
      check_val("t3_pc4",    pc_o, 32'h200);
      check_val("t3_in4",    instr_o, 32'hFFFF_FDFF);

      // ---- 4: redirect beats stall ----
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      tick();
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      check_val("t4_v",      {31'd0, valid_o}, 32'd0);
      check_val("t4_addr",   imem.addr, 32'h300);
      tick();
      check_val("t4_pc",     pc_o, 32'h300);
      check_val("t4_in",     instr_o, 32'hFFFF_FCFF);

      // ---- 5: asynchronous reset mid-cycle ----
      check_val("t5_req_pre", {31'd0, imem.req}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check_val("t5_req",    {31'd0, imem.req}, 32'd0);
      check_val("t5_v",      {31'd0, valid_o}, 32'd0);
      check_val("t5_addr",   imem.addr, 32'h100);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();
      check_val("t5_req2",   {31'd0, imem.req}, 32'd1);
      check_val("t5_addr2",  imem.addr, 32'h100);
      tick();
      check_val("t5_pc",     pc_o, 32'h100);

      // ---- 6: misaligned redirect target 0x202 ----
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h202;
      tick();
      redirect_i = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_EN
      stall_i = 1'b1;
      check_val("t6_mis",    {31'd0, misalign_o}, 32'd1);
      check_val("t6_v",      {31'd0, valid_o}, 32'd1);
      check_val("t6_pc",     pc_o, 32'h202);
      check_val("t6_in",     instr_o, 32'd0);
      check_val("t6_req",    {31'd0, imem.req}, 32'd0);
      tick();
      check_val("t6_req2",   {31'd0, imem.req}, 32'd0);
      check_val("t6_pc2",    pc_o, 32'h202);
      stall_i = 1'b0;
`else
      check_val("t6_addr",   imem.addr, 32'h200);
      check_val("t6_req",    {31'd0, imem.req}, 32'd1);
      check_val("t6_v",      {31'd0, valid_o}, 32'd0);
      tick();
      check_val("t6_pc",     pc_o, 32'h200);
      check_val("t6_in",     instr_o, 32'hFFFF_FDFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
